residual_seq: RTL and testbench
===============================

# residual_seq

Per-macroblock residual block scheduler. It walks the 4:2:0 CAVLC residual syntax order for one macroblock: Intra16x16 DC, 16 luma 4x4 blocks, chroma DC Cb/Cr, then 8 chroma AC blocks. For each block it drives `residual_state`, `blk_idx` and a `residual_start` pulse into `residual_ctrl`, then waits for `residual_valid` before moving on. Blocks with no coded coefficients, as set by the coded_block_pattern, are issued in their `_0` states so the transform still writes zero residual.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `ena`  in  1  global enable; all state advances only when high
- `mb_start`  in  1  one-cycle pulse; starts residual sequencing of a macroblock (honoured in IDLE only)
- `intra16x16`  in  1  macroblock is Intra16x16 (sampled with `mb_start`)
- `cbp_luma`  in  4  coded_block_pattern luma bits, one per 8x8 (sampled with `mb_start`)
- `cbp_chroma`  in  2  coded_block_pattern chroma 0/1/2 (sampled with `mb_start`); 3 is treated as 2
- `residual_state`  out  4  current block type code
- `blk_idx`  out  4  block index within type: luma 0–15 z-scan, chroma AC 0–3, DC 0
- `residual_start`  out  1  one-cycle start to `residual_ctrl`
- `residual_valid`  in  1  block finished; sticky high until next `residual_start`
- `busy`  out  1  high from the cycle after the accepted `mb_start` through DONE
- `mb_residual_done`  out  1  one-cycle pulse when the last block completes

## Operation
- `residual_state` codes (defines.v values):
  - Idle = 0
  - Intra16x16DCLevel = 1
  - Intra16x16ACLevel = 2
  - Intra16x16ACLevel_0 = 3
  - LumaLevel = 4
  - LumaLevel_0 = 5
  - ChromaDCLevel_Cb = 6
  - ChromaDCLevel_Cr = 7
  - ChromaACLevel_Cb = 8
  - ChromaACLevel_Cb_0 = 9
  - ChromaACLevel_Cr = 10
  - ChromaACLevel_Cr_0 = 11
- Block order:
  - If `intra16x16`: DC (code 1, idx 0), then idx 0..15 with code 2 if `cbp_luma[idx[3:2]]`, else 3.
  - Otherwise: idx 0..15 with code 4 if `cbp_luma[idx[3:2]]`, else 5.
  - If `cbp_chroma != 0`: Cb DC (6), then Cr DC (7), both idx 0. Skipped entirely when `cbp_chroma == 0`.
  - Cb AC idx 0..3 with code 8 if `cbp_chroma == 2`, else 9.
  - Cr AC idx 0..3 with code 10 if `cbp_chroma == 2`, else 11.
- Block count per macroblock: 24 + `intra16x16` + 2·(`cbp_chroma != 0`). Range 24–27.
- Control FSM: IDLE, START, WAIT, DONE.
  - IDLE: `residual_state` = 0. On `mb_start`, latch the config, load the first block, go to START.
  - START: `residual_start` = 1 for exactly one `ena` cycle, then WAIT.
  - WAIT: when `residual_valid` = 1, either load the next block and go to START, or go to DONE if that was the last block.
  - DONE: `mb_residual_done` = 1, then IDLE.
- Outputs `residual_start`, `mb_residual_done` and `busy` decode directly from the state register. `residual_state` and `blk_idx` are registered and are stable from START through WAIT.
- Internal block counter: 5 bits, 0..26. The phase/type sub-state tracks the chroma-DC skip; the counter never wraps past the last block.

## Timing
- Reset values:
  - FSM = IDLE
  - `residual_state` = 0, `blk_idx` = 0
  - `residual_start` = 0, `busy` = 0, `mb_residual_done` = 0
  - latched config = 0
- `mb_start` seen in IDLE at cycle T: START at T+1 (first `residual_start` high at T+1).
- `residual_valid` is ignored in the START cycle. In WAIT, the first cycle with `residual_valid` high at T gives the next START at T+1. Minimum per-block period is 2 cycles.
- Final block: `residual_valid` at T gives `mb_residual_done` at T+1 and IDLE at T+2. A new `mb_start` is accepted at T+2.
- `ena` low: state, counters and registered outputs hold. `residual_start` stays high if frozen in START; `residual_ctrl` is gated by the same `ena`.
- `mb_start` outside IDLE, including during DONE, is ignored.
- `residual_valid` high in IDLE or DONE is ignored.
- `rst_n` low mid-macroblock: immediate return to reset values. No done pulse is produced.

## Test plan
- Inter MB, `cbp_luma` = 0, `cbp_chroma` = 0. Bench returns `residual_valid` 2 cycles after each start; `mb_start` at cycle 0.
  - Required: 24 starts at cycles 1+3k.
  - States: 5 ×16 (idx 0..15), 9 ×4, 11 ×4.
  - `mb_residual_done` at cycle 73.
- Intra16x16, `cbp_luma` = 4'hF, `cbp_chroma` = 2.
  - Required: 27 blocks in order 1, 2 ×16, 6, 7, 8 ×4, 10 ×4.
  - `busy` high cycles 1..done; exactly one done pulse.
- Inter, `cbp_luma` = 4'b0101, `cbp_chroma` = 1.
  - Luma idx 0–3 and 8–11 use code 4; idx 4–7 and 12–15 use code 5.
  - Chroma DC 6, 7 issued; AC uses codes 9 and 11.
- Variable latency (`residual_valid` 1–20 cycles) with `ena` toggled randomly.
  - Exactly one start per block.
  - State and idx stable while waiting.
  - Frozen outputs hold while `ena` = 0.
- `mb_start` asserted mid-sequence and in the DONE cycle: ignored, sequence unaffected.
  - `mb_start` in the cycle after DONE: accepted.
- `rst_n` pulsed low while in WAIT at block 10: all outputs return to 0 immediately.
  - A following `mb_start` restarts from block 0.

Source files
------------

// File: rtl/residual_seq_if.sv
// rtl/residual_seq_if.sv - macroblock request and residual block handshake bundle
interface residual_seq_if;
    logic       mb_start;
    logic       intra16x16;
    logic [3:0] cbp_luma;
    logic [1:0] cbp_chroma;
    logic [3:0] residual_state;
    logic [3:0] blk_idx;
    logic       residual_start;
    logic       residual_valid;
    logic       busy;
    logic       mb_residual_done;

    modport master (
        input  mb_start, intra16x16, cbp_luma, cbp_chroma, residual_valid,
        output residual_state, blk_idx, residual_start, busy, mb_residual_done
    );

    modport slave (
        output mb_start, intra16x16, cbp_luma, cbp_chroma, residual_valid,
        input  residual_state, blk_idx, residual_start, busy, mb_residual_done
    );
endinterface

// File: rtl/residual_seq.sv
// rtl/residual_seq.sv - walks the 4:2:0 CAVLC residual block order of one macroblock
module residual_seq (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    residual_seq_if.master bus
);
    localparam logic [3:0] RS_IDLE      = 4'd0;
    localparam logic [3:0] RS_I16_DC    = 4'd1;
    localparam logic [3:0] RS_I16_AC    = 4'd2;
    localparam logic [3:0] RS_I16_AC_0  = 4'd3;
    localparam logic [3:0] RS_LUMA      = 4'd4;
    localparam logic [3:0] RS_LUMA_0    = 4'd5;
    localparam logic [3:0] RS_CB_DC     = 4'd6;
    localparam logic [3:0] RS_CR_DC     = 4'd7;
    localparam logic [3:0] RS_CB_AC     = 4'd8;
    localparam logic [3:0] RS_CB_AC_0   = 4'd9;
    localparam logic [3:0] RS_CR_AC     = 4'd10;
    localparam logic [3:0] RS_CR_AC_0   = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} fsm_t;

    fsm_t       state_q, state_d;
    logic [4:0] blk_cnt_q, blk_cnt_d;
    logic [3:0] res_state_q, res_state_d;
    logic [3:0] blk_idx_q, blk_idx_d;
    logic       cfg_intra_q;
    logic [3:0] cfg_luma_q;
    logic [1:0] cfg_chroma_q;

    logic       cfg_load;
    logic       lk_intra;
    logic [3:0] lk_luma;
    logic [1:0] lk_chroma;
    logic [4:0] lk_cnt;
    logic [3:0] lk_code;
    logic [3:0] lk_idx;
    logic [4:0] k;
    logic       luma_coded;
    logic       chroma_ac_coded;
    logic [4:0] last_cnt;

    // In IDLE the first block is decoded from the live inputs; afterwards from the latched config.
    always_comb begin
        if (state_q == S_IDLE) begin
            lk_intra  = bus.intra16x16;
            lk_luma   = bus.cbp_luma;
            lk_chroma = (bus.cbp_chroma == 2'd3) ? 2'd2 : bus.cbp_chroma;
            lk_cnt    = 5'd0;
        end else begin
            lk_intra  = cfg_intra_q;
            lk_luma   = cfg_luma_q;
            lk_chroma = cfg_chroma_q;
            lk_cnt    = blk_cnt_q + 5'd1;
        end
    end

    always_comb begin
        k               = lk_cnt;
        lk_code         = RS_IDLE;
        lk_idx          = 4'd0;
        luma_coded      = 1'b0;
        chroma_ac_coded = (lk_chroma == 2'd2);
        if (lk_intra && k == 5'd0) begin
            lk_code = RS_I16_DC;
        end else begin
            if (lk_intra) k = k - 5'd1;
            if (k < 5'd16) begin
                lk_idx     = k[3:0];
                luma_coded = lk_luma[k[3:2]];
                if (lk_intra) lk_code = luma_coded ? RS_I16_AC : RS_I16_AC_0;
                else          lk_code = luma_coded ? RS_LUMA : RS_LUMA_0;
            end else begin
                k = k - 5'd16;
                if (lk_chroma != 2'd0 && k < 5'd2) begin
                    lk_code = k[0] ? RS_CR_DC : RS_CB_DC;
                end else begin
                    if (lk_chroma != 2'd0) k = k - 5'd2;
                    lk_idx = {2'b00, k[1:0]};
                    if (k[2]) lk_code = chroma_ac_coded ? RS_CR_AC : RS_CR_AC_0;
                    else      lk_code = chroma_ac_coded ? RS_CB_AC : RS_CB_AC_0;
                end
            end
        end
    end

    assign last_cnt = 5'd23 + {4'd0, cfg_intra_q} + ((cfg_chroma_q != 2'd0) ? 5'd2 : 5'd0);
    assign cfg_load = ena && (state_q == S_IDLE) && bus.mb_start;

    always_comb begin
        state_d     = state_q;
        blk_cnt_d   = blk_cnt_q;
        res_state_d = res_state_q;
        blk_idx_d   = blk_idx_q;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.mb_start) begin
                        state_d     = S_START;
                        blk_cnt_d   = 5'd0;
                        res_state_d = lk_code;
                        blk_idx_d   = lk_idx;
                    end
                end
                S_START: state_d = S_WAIT;
                S_WAIT: begin
                    if (bus.residual_valid) begin
                        if (blk_cnt_q == last_cnt) begin
                            state_d     = S_DONE;
                            res_state_d = RS_IDLE;
                            blk_idx_d   = 4'd0;
                        end else begin
                            state_d     = S_START;
                            blk_cnt_d   = lk_cnt;
                            res_state_d = lk_code;
                            blk_idx_d   = lk_idx;
                        end
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    blk_cnt_d = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            blk_cnt_q    <= 5'd0;
            res_state_q  <= RS_IDLE;
            blk_idx_q    <= 4'd0;
            cfg_intra_q  <= 1'b0;
            cfg_luma_q   <= 4'd0;
            cfg_chroma_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            blk_cnt_q   <= blk_cnt_d;
            res_state_q <= res_state_d;
            blk_idx_q   <= blk_idx_d;
            if (cfg_load) begin
                cfg_intra_q  <= lk_intra;
                cfg_luma_q   <= lk_luma;
                cfg_chroma_q <= lk_chroma;
            end
        end
    end

    assign bus.residual_state   = res_state_q;
    assign bus.blk_idx          = blk_idx_q;
    assign bus.residual_start   = (state_q == S_START);
    assign bus.busy             = (state_q != S_IDLE);
    assign bus.mb_residual_done = (state_q == S_DONE);
endmodule

// File: tb/tb_residual_seq.sv
// tb/tb_residual_seq.sv - randomized bench for residual_seq against a block-list model
module tb_residual_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;

    residual_seq_if bus ();

    residual_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;
    // ph: 0 idle, 1 start cycle, 2 waiting for valid, 3 done pulse
    int ph = 0;
    int q[$];
    int exp_list[$];
    int obs[$];
    int start_cyc[$];
    int done_cyc = -1;
    int done_cnt = 0;
    int cd = 0;
    int lat_min = 2;
    int lat_max = 2;
    int base;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Expected block list, entries are code*16 + idx.
    function automatic void build(input bit intra, input logic [3:0] luma, input logic [1:0] ch);
        int c;
        c = (ch == 2'd3) ? 2 : int'(ch);
        q.delete();
        if (intra) q.push_back(1 << 4);
        for (int i = 0; i < 16; i++)
            q.push_back(((luma[i / 4] ? (intra ? 2 : 4) : (intra ? 3 : 5)) << 4) | i);
        if (c != 0) begin
            q.push_back(6 << 4);
            q.push_back(7 << 4);
        end
        for (int i = 0; i < 4; i++) q.push_back(((c == 2 ? 8 : 9) << 4) | i);
        for (int i = 0; i < 4; i++) q.push_back(((c == 2 ? 10 : 11) << 4) | i);
    endfunction

    always @(negedge clk) begin
        int e;
        if (cmp_en) begin
            chk(bus.residual_start == (ph == 1), "residual_start", bus.residual_start, ph == 1);
            chk(bus.busy == (ph != 0), "busy", bus.busy, ph != 0);
            chk(bus.mb_residual_done == (ph == 3), "mb_residual_done", bus.mb_residual_done, ph == 3);
            if (ph == 1 || ph == 2) begin
                e = q[0];
                chk(int'(bus.residual_state) == (e >> 4), "residual_state", bus.residual_state, e >> 4);
                chk(int'(bus.blk_idx) == (e & 15), "blk_idx", bus.blk_idx, e & 15);
            end else if (ph == 0) begin
                chk(bus.residual_state == 4'd0, "idle_state", bus.residual_state, 0);
                chk(bus.blk_idx == 4'd0, "idle_idx", bus.blk_idx, 0);
            end
            if (bus.residual_start && ena) begin
                obs.push_back((int'(bus.residual_state) << 4) | int'(bus.blk_idx));
                start_cyc.push_back(cyc);
            end
            if (bus.mb_residual_done && ena) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
    end

    task automatic step();
        bit s_start, s_ena, s_valid, s_mb, s_intra;
        logic [3:0] s_luma;
        logic [1:0] s_ch;
        s_start = bus.residual_start;
        s_ena   = ena;
        s_valid = bus.residual_valid;
        s_mb    = bus.mb_start;
        s_intra = bus.intra16x16;
        s_luma  = bus.cbp_luma;
        s_ch    = bus.cbp_chroma;
        @(posedge clk);
        cyc++;
        #1;
        if (rst_n && s_ena) begin
            case (ph)
                0: if (s_mb) begin
                    build(s_intra, s_luma, s_ch);
                    exp_list = q;
                    ph = 1;
                end
                1: ph = 2;
                2: if (s_valid) begin
                    void'(q.pop_front());
                    ph = (q.size() == 0) ? 3 : 1;
                end
                default: ph = 0;
            endcase
        end
        if (s_start && s_ena) begin
            bus.residual_valid = 1'b0;
            cd = int'($urandom_range(lat_max, lat_min)) - 1;
            if (cd == 0) bus.residual_valid = 1'b1;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) bus.residual_valid = 1'b1;
        end
    endtask

    task automatic run_mb(input bit intra, input logic [3:0] luma, input logic [1:0] ch,
                          input int pct, input bit stray, input bit probe, input int rst_at,
                          output int b);
        int budget;
        bus.intra16x16 = intra;
        bus.cbp_luma   = luma;
        bus.cbp_chroma = ch;
        obs.delete();
        start_cyc.delete();
        done_cyc = -1;
        done_cnt = 0;
        bus.mb_start = 1'b1;
        ena = 1'b1;
        b = cyc;
        step();
        chk(bus.residual_start == 1'b1, "mb_accept", bus.residual_start, 1);
        bus.mb_start = 1'b0;
        budget = 0;
        while (ph != 0 && budget < 4000) begin
            budget++;
            if (rst_at >= 0 && ph == 2 && (exp_list.size() - q.size()) == rst_at) begin
                bus.mb_start = 1'b0;
                rst_n = 1'b0;
                ph = 0;
                q.delete();
                cd = 0;
                bus.residual_valid = 1'b0;
                #1;
                chk(bus.residual_start == 1'b0, "rst_start", bus.residual_start, 0);
                chk(bus.busy == 1'b0, "rst_busy", bus.busy, 0);
                chk(bus.mb_residual_done == 1'b0, "rst_done", bus.mb_residual_done, 0);
                chk(bus.residual_state == 4'd0, "rst_state", bus.residual_state, 0);
                chk(bus.blk_idx == 4'd0, "rst_idx", bus.blk_idx, 0);
                step();
                step();
                rst_n = 1'b1;
                ena = 1'b1;
                step();
                chk(done_cnt == 0, "rst_no_done", done_cnt, 0);
                return;
            end
            ena = ($urandom_range(0, 99) < pct);
            bus.mb_start = stray && ($urandom_range(0, 7) == 0);
            if (probe && ph == 3) begin
                ena = 1'b1;
                bus.mb_start = 1'b1;
            end
            step();
        end
        if (budget >= 4000) chk(1'b0, "timeout", budget, 0);
        if (!probe) bus.mb_start = 1'b0;
        ena = 1'b1;
        chk(obs.size() == exp_list.size(), "block_count", obs.size(), exp_list.size());
        for (int i = 0; i < obs.size() && i < exp_list.size(); i++)
            chk(obs[i] == exp_list[i], "block_order", obs[i], exp_list[i]);
        chk(done_cnt == 1, "done_pulses", done_cnt, 1);
    endtask

    initial begin
        bus.mb_start = 1'b0;
        bus.intra16x16 = 1'b0;
        bus.cbp_luma = 4'd0;
        bus.cbp_chroma = 2'd0;
        bus.residual_valid = 1'b0;
        #1;
        cmp_en = 1'b1;
        repeat (3) step();
        chk(bus.busy == 1'b0, "reset_busy", bus.busy, 0);
        chk(bus.residual_start == 1'b0, "reset_start", bus.residual_start, 0);
        chk(bus.mb_residual_done == 1'b0, "reset_done", bus.mb_residual_done, 0);
        chk(bus.residual_state == 4'd0, "reset_state", bus.residual_state, 0);
        rst_n = 1'b1;
        ena = 1'b1;
        step();

        build(1'b0, 4'h0, 2'd0);
        chk(q.size() == 24, "pin0_size", q.size(), 24);
        chk(q[15] == 'h5F, "pin0_q15", q[15], 'h5F);
        chk(q[16] == 'h90, "pin0_q16", q[16], 'h90);
        chk(q[23] == 'hB3, "pin0_q23", q[23], 'hB3);
        build(1'b1, 4'hF, 2'd2);
        chk(q.size() == 27, "pin1_size", q.size(), 27);
        chk(q[0] == 'h10, "pin1_q0", q[0], 'h10);
        chk(q[1] == 'h20, "pin1_q1", q[1], 'h20);
        chk(q[18] == 'h70, "pin1_q18", q[18], 'h70);
        chk(q[26] == 'hA3, "pin1_q26", q[26], 'hA3);
        build(1'b0, 4'b0101, 2'd1);
        chk(q.size() == 26, "pin2_size", q.size(), 26);
        chk(q[4] == 'h54, "pin2_q4", q[4], 'h54);
        chk(q[8] == 'h48, "pin2_q8", q[8], 'h48);
        chk(q[17] == 'h70, "pin2_q17", q[17], 'h70);
        chk(q[25] == 'hB3, "pin2_q25", q[25], 'hB3);
        build(1'b0, 4'h0, 2'd3);
        chk(q[18] == 'h80, "pin3_q18", q[18], 'h80);
        q.delete();

        lat_min = 2; lat_max = 2;
        run_mb(1'b0, 4'h0, 2'd0, 100, 1'b0, 1'b0, -1, base);
        chk(start_cyc.size() == 24, "mb0_starts", start_cyc.size(), 24);
        for (int k2 = 0; k2 < start_cyc.size(); k2++)
            chk(start_cyc[k2] - base == 1 + 3 * k2, "mb0_start_cycle", start_cyc[k2] - base, 1 + 3 * k2);
        chk(done_cyc - base == 73, "mb0_done_cycle", done_cyc - base, 73);
        repeat (2) step();

        run_mb(1'b1, 4'hF, 2'd2, 100, 1'b0, 1'b0, -1, base);
        lat_min = 1; lat_max = 3;
        run_mb(1'b0, 4'b0101, 2'd1, 100, 1'b0, 1'b0, -1, base);
        run_mb(1'b1, 4'b1010, 2'd3, 80, 1'b1, 1'b0, -1, base);

        lat_min = 1; lat_max = 20;
        for (int n = 0; n < 8; n++)
            run_mb(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   60, 1'b1, 1'b0, -1, base);

        run_mb(1'b0, 4'b0011, 2'd2, 70, 1'b1, 1'b1, -1, base);
        run_mb(1'b1, 4'b1100, 2'd1, 70, 1'b1, 1'b0, -1, base);

        run_mb(1'b0, 4'b1111, 2'd2, 70, 1'b1, 1'b0, 10, base);
        run_mb(1'b0, 4'b0110, 2'd0, 70, 1'b0, 1'b0, -1, base);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
